// File: rtl/note_judge.sv
// Hit-window judge: scores fresh button presses against the expected note lanes.
// Optional perfect grading is enabled by defining NOTE_JUDGE_PERFECT_EN.
module note_judge #(
  parameter int WINDOW_CYC  = 25000000,
  parameter int SCORE_W     = 16,
  parameter int PERFECT_CYC = 5000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               note_valid,
  input  logic [4:0]         note_lanes,
  input  logic [4:0]         btn,
  output logic               hit,
  output logic               miss,
  output logic [7:0]         combo,
  output logic [SCORE_W-1:0] score,
  output logic               perfect
);

  localparam int TW = $clog2(WINDOW_CYC);
  localparam int SW = SCORE_W + 4;

  localparam logic [TW-1:0] T_LOAD = TW'(WINDOW_CYC - 1);
  localparam logic [TW-1:0] T_PERF = TW'(WINDOW_CYC - 1 - PERFECT_CYC);

`ifdef NOTE_JUDGE_PERFECT_EN
  localparam logic PERF_EN = 1'b1;
`else
  localparam logic PERF_EN = 1'b0;
`endif

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OPEN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [TW-1:0] timer;
  logic [4:0]    expected;
  logic [4:0]    collected;
  logic [4:0]    btn_prev;

  logic [4:0] press;
  logic       is_open;
  logic       wrong;
  logic       full;
  logic       j_hit;
  logic       j_miss;
  logic       j_perf;
  logic       early;
  logic [2:0] mult;
  logic [3:0] gain;
  logic [SW-1:0]      sum;
  logic [SCORE_W-1:0] score_nxt;
  logic [7:0]         combo_inc;

  assign press   = btn & ~btn_prev;
  assign is_open = (state == S_OPEN);
  assign wrong   = |(press & ~expected);
  assign full    = ((collected | press) == expected);

  // a new note arriving mid-window forces a miss for the pending one
  assign j_hit  = is_open & ~wrong & full;
  assign j_miss = is_open & ~j_hit
                & (wrong | (timer == '0) | note_valid);

  assign early  = PERF_EN & (timer > T_PERF);
  assign j_perf = j_hit & early;

  always_comb begin
    mult = 3'd4;
    unique case (1'b1)
      (combo < 8'd8):                   mult = 3'd1;
      (combo >= 8'd8 && combo < 8'd16):  mult = 3'd2;
      (combo >= 8'd16 && combo < 8'd32): mult = 3'd3;
      (combo >= 8'd32):                  mult = 3'd4;
      default:                           mult = 3'd4;
    endcase
  end

  assign gain = j_perf ? {mult, 1'b0} : {1'b0, mult};
  assign sum  = SW'(score) + SW'(gain);

  assign score_nxt = (|sum[SW-1:SCORE_W])
                   ? {SCORE_W{1'b1}}
                   : sum[SCORE_W-1:0];

  assign combo_inc = (combo == 8'hff) ? combo : combo + 8'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      timer     <= '0;
      expected  <= '0;
      collected <= '0;
      btn_prev  <= '0;
      hit       <= 1'b0;
      miss      <= 1'b0;
      perfect   <= 1'b0;
      combo     <= '0;
      score     <= '0;
    end else begin
      btn_prev <= btn;
      hit      <= j_hit;
      miss     <= j_miss;
      perfect  <= j_perf;
      if (j_hit) begin
        combo <= combo_inc;
        score <= score_nxt;
      end else if (j_miss) begin
        combo <= '0;
      end
      if (note_valid) begin
        if (note_lanes != '0) begin
          state     <= S_OPEN;
          expected  <= note_lanes;
          collected <= '0;
          timer     <= T_LOAD;
        end else begin
          state <= S_IDLE;
        end
      end else if (is_open) begin
        if (j_hit | j_miss) begin
          state <= S_DONE;
        end else begin
          collected <= collected | press;
          timer     <= timer - TW'(1);
        end
      end
    end
  end

endmodule
